// File: rtl/axis2axi_wr_responder_if.sv
// Bus bundle for axis2axi_wr_responder: request/response AXIS flit streams plus the AXI4 write master.
interface axis2axi_wr_responder_if #(
    parameter int unsigned ADDR_WIDTH         = 16,
    parameter int unsigned DATA_WIDTH         = 8,
    parameter int unsigned ID_W_WIDTH         = 5,
    parameter int unsigned AXIS_CHANNEL_WIDTH = 40
);
    logic                          s_axis_tvalid;
    logic                          s_axis_tready;
    logic [AXIS_CHANNEL_WIDTH-1:0] s_axis_tdata;
    logic                          s_axis_tlast;

    logic                          m_axis_tvalid;
    logic                          m_axis_tready;
    logic [AXIS_CHANNEL_WIDTH-1:0] m_axis_tdata;
    logic                          m_axis_tlast;

    logic [ID_W_WIDTH-1:0]         m_axi_awid;
    logic [ADDR_WIDTH-1:0]         m_axi_awaddr;
    logic [7:0]                    m_axi_awlen;
    logic [2:0]                    m_axi_awsize;
    logic [1:0]                    m_axi_awburst;
    logic                          m_axi_awvalid;
    logic                          m_axi_awready;

    logic [DATA_WIDTH-1:0]         m_axi_wdata;
    logic                          m_axi_wlast;
    logic                          m_axi_wvalid;
    logic                          m_axi_wready;

    logic [ID_W_WIDTH-1:0]         m_axi_bid;
    logic [1:0]                    m_axi_bresp;
    logic                          m_axi_bvalid;
    logic                          m_axi_bready;

    // Responder side: sinks request flits, sources response flits, masters AXI.
    modport master (
        input  s_axis_tvalid, s_axis_tdata, s_axis_tlast,
        output s_axis_tready,
        output m_axis_tvalid, m_axis_tdata, m_axis_tlast,
        input  m_axis_tready,
        output m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awvalid,
        input  m_axi_awready,
        output m_axi_wdata, m_axi_wlast, m_axi_wvalid,
        input  m_axi_wready,
        input  m_axi_bid, m_axi_bresp, m_axi_bvalid,
        output m_axi_bready
    );

    modport slave (
        output s_axis_tvalid, s_axis_tdata, s_axis_tlast,
        input  s_axis_tready,
        input  m_axis_tvalid, m_axis_tdata, m_axis_tlast,
        output m_axis_tready,
        input  m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awvalid,
        output m_axi_awready,
        input  m_axi_wdata, m_axi_wlast, m_axi_wvalid,
        output m_axi_wready,
        output m_axi_bid, m_axi_bresp, m_axi_bvalid,
        input  m_axi_bready
    );
endinterface

// File: rtl/axis2axi_wr_responder.sv
// Mesh write endpoint: replays an AW/W request packet as one AXI4 write burst and returns a B packet.
// Optional B-channel timeout is enabled by defining WR_B_TIMEOUT_EN.
module axis2axi_wr_responder #(
    parameter int unsigned ADDR_WIDTH         = 16,
    parameter int unsigned DATA_WIDTH         = 8,
    parameter int unsigned ID_W_WIDTH         = 5,
    parameter int unsigned AXIS_CHANNEL_WIDTH = 40,
    parameter int unsigned ROUTER_X           = 0,
    parameter int unsigned ROUTER_Y           = 0,
    parameter int unsigned MAX_ROUTERS_X      = 4,
    parameter int unsigned MAX_ROUTERS_Y      = 4
`ifdef WR_B_TIMEOUT_EN
    ,parameter int unsigned TIMEOUT_CYCLES    = 1024
`endif
) (
    input  logic                    ACLK,
    input  logic                    ARESETn,
    axis2axi_wr_responder_if.master bus,
    output logic                    proto_err_o
);
    localparam int unsigned X_W      = $clog2(MAX_ROUTERS_X);
    localparam int unsigned Y_W      = $clog2(MAX_ROUTERS_Y);
    localparam int unsigned DX_LSB   = 8;
    localparam int unsigned DY_LSB   = DX_LSB + X_W;
    localparam int unsigned SX_LSB   = DY_LSB + Y_W;
    localparam int unsigned SY_LSB   = SX_LSB + X_W;
    localparam int unsigned LEN_LSB  = 5;
    localparam int unsigned ADDR_LSB = 13;
    localparam int unsigned ID_LSB   = ADDR_LSB + ADDR_WIDTH;
    localparam int unsigned SUB_W    = ID_LSB + ID_W_WIDTH;
    localparam logic [7:0]  TYPE_AW  = 8'h01;
    localparam logic [7:0]  TYPE_B   = 8'h02;

    typedef enum logic [3:0] {
        S_IDLE, S_SUB, S_AW, S_W, S_PAD, S_DRAIN, S_B, S_RH, S_RB, S_DROP
    } state_t;

    state_t                        state_q, state_d;
    logic                          run_q;
    logic                          err_q, err_d;
    logic [7:0]                    cnt_q, cnt_d;
    logic [X_W-1:0]                src_x_q;
    logic [Y_W-1:0]                src_y_q;
    logic [ID_W_WIDTH-1:0]         awid_q, bid_q;
    logic [ADDR_WIDTH-1:0]         awaddr_q;
    logic [7:0]                    awlen_q;
    logic [2:0]                    awsize_q;
    logic [1:0]                    awburst_q;
    logic                          lat_src, lat_aw, lat_b, b_timeout;
    logic                          s_rdy_c, wvalid_c, wlast_c, bready_c, tvalid_c, tlast_c;
    logic [DATA_WIDTH-1:0]         wdata_c;
    logic [AXIS_CHANNEL_WIDTH-1:0] tdata_c, resp_hdr_c;
    logic                          tmo_c;

`ifdef WR_B_TIMEOUT_EN
    localparam int unsigned T_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [T_W-1:0] tcnt_q;

    // Cycles spent waiting in B; restarts on every entry.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn)              tcnt_q <= '0;
        else if (state_q != S_B)   tcnt_q <= '0;
        else                       tcnt_q <= tcnt_q + T_W'(1);
    end
    assign tmo_c = (tcnt_q == T_W'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_c = 1'b0;
`endif

    // Response header: the request's source becomes the destination.
    always_comb begin
        resp_hdr_c                = '0;
        resp_hdr_c[7:0]           = TYPE_B;
        resp_hdr_c[DX_LSB +: X_W] = src_x_q;
        resp_hdr_c[DY_LSB +: Y_W] = src_y_q;
        resp_hdr_c[SX_LSB +: X_W] = X_W'(ROUTER_X);
        resp_hdr_c[SY_LSB +: Y_W] = Y_W'(ROUTER_Y);
    end

    // Next-state and handshake decode.
    always_comb begin
        state_d   = state_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        lat_src   = 1'b0;
        lat_aw    = 1'b0;
        lat_b     = 1'b0;
        b_timeout = 1'b0;
        s_rdy_c   = 1'b0;
        wvalid_c  = 1'b0;
        wdata_c   = '0;
        wlast_c   = 1'b0;
        bready_c  = 1'b0;
        tvalid_c  = 1'b0;
        tdata_c   = '0;
        tlast_c   = 1'b0;
        case (state_q)
            S_IDLE: begin
                s_rdy_c = run_q;
`ifdef WR_B_TIMEOUT_EN
                bready_c = run_q;
`endif
                if (run_q && bus.s_axis_tvalid) begin
                    lat_src = 1'b1;
                    if (bus.s_axis_tdata[7:0] == TYPE_AW && !bus.s_axis_tlast) begin
                        state_d = S_SUB;
                    end else begin
                        err_d = 1'b1;
                        if (!bus.s_axis_tlast) state_d = S_DROP;
                    end
                end
            end
            S_SUB: begin
                s_rdy_c = 1'b1;
                if (bus.s_axis_tvalid) begin
                    lat_aw = 1'b1;
                    cnt_d  = bus.s_axis_tdata[LEN_LSB +: 8];
                    if (bus.s_axis_tlast) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_AW;
                    end
                end
            end
            S_AW: begin
                if (bus.m_axi_awready) state_d = S_W;
            end
            S_W: begin
                wvalid_c = bus.s_axis_tvalid;
                s_rdy_c  = bus.m_axi_wready;
                wdata_c  = bus.s_axis_tdata[DATA_WIDTH-1:0];
                wlast_c  = (cnt_q == 8'd0);
                if (bus.s_axis_tvalid && bus.m_axi_wready) begin
                    cnt_d = cnt_q - 8'd1;
                    if (cnt_q == 8'd0) begin
                        if (bus.s_axis_tlast) begin
                            state_d = S_B;
                        end else begin
                            err_d   = 1'b1;
                            state_d = S_DRAIN;
                        end
                    end else if (bus.s_axis_tlast) begin
                        err_d   = 1'b1;
                        state_d = S_PAD;
                    end
                end
            end
            S_PAD: begin
                wvalid_c = 1'b1;
                wlast_c  = (cnt_q == 8'd0);
                if (bus.m_axi_wready) begin
                    cnt_d = cnt_q - 8'd1;
                    if (cnt_q == 8'd0) state_d = S_B;
                end
            end
            S_DRAIN: begin
                s_rdy_c = 1'b1;
                if (bus.s_axis_tvalid && bus.s_axis_tlast) state_d = S_B;
            end
            S_B: begin
                bready_c = 1'b1;
                if (bus.m_axi_bvalid) begin
                    lat_b   = 1'b1;
                    state_d = S_RH;
                end else if (tmo_c) begin
                    b_timeout = 1'b1;
                    err_d     = 1'b1;
                    state_d   = S_RH;
                end
            end
            S_RH: begin
                tvalid_c = 1'b1;
                tdata_c  = resp_hdr_c;
                if (bus.m_axis_tready) state_d = S_RB;
            end
            S_RB: begin
                tvalid_c = 1'b1;
                tdata_c  = AXIS_CHANNEL_WIDTH'(bid_q);
                tlast_c  = 1'b1;
                if (bus.m_axis_tready) state_d = S_IDLE;
            end
            S_DROP: begin
                s_rdy_c = 1'b1;
                if (bus.s_axis_tvalid && bus.s_axis_tlast) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and latched packet fields.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q   <= S_IDLE;
            run_q     <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            src_x_q   <= '0;
            src_y_q   <= '0;
            awid_q    <= '0;
            awaddr_q  <= '0;
            awlen_q   <= '0;
            awsize_q  <= '0;
            awburst_q <= '0;
            bid_q     <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            if (lat_src) begin
                src_x_q <= bus.s_axis_tdata[SX_LSB +: X_W];
                src_y_q <= bus.s_axis_tdata[SY_LSB +: Y_W];
            end
            if (lat_aw) begin
                awburst_q <= bus.s_axis_tdata[1:0];
                awsize_q  <= bus.s_axis_tdata[4:2];
                awlen_q   <= bus.s_axis_tdata[LEN_LSB +: 8];
                awaddr_q  <= bus.s_axis_tdata[ADDR_LSB +: ADDR_WIDTH];
                awid_q    <= bus.s_axis_tdata[ID_LSB +: ID_W_WIDTH];
            end
            if (lat_b)          bid_q <= bus.m_axi_bid;
            else if (b_timeout) bid_q <= awid_q;
        end
    end

    assign bus.s_axis_tready = s_rdy_c;
    assign bus.m_axis_tvalid = tvalid_c;
    assign bus.m_axis_tdata  = tdata_c;
    assign bus.m_axis_tlast  = tlast_c;
    assign bus.m_axi_awid    = awid_q;
    assign bus.m_axi_awaddr  = awaddr_q;
    assign bus.m_axi_awlen   = awlen_q;
    assign bus.m_axi_awsize  = awsize_q;
    assign bus.m_axi_awburst = awburst_q;
    assign bus.m_axi_awvalid = (state_q == S_AW);
    assign bus.m_axi_wdata   = wdata_c;
    assign bus.m_axi_wlast   = wlast_c;
    assign bus.m_axi_wvalid  = wvalid_c;
    assign bus.m_axi_bready  = bready_c;
    assign proto_err_o       = err_q;

    // Flit bits above the AW subheader and bresp carry nothing this endpoint uses.
    logic unused_bits;
    assign unused_bits = ^{bus.s_axis_tdata[AXIS_CHANNEL_WIDTH-1:SUB_W], bus.m_axi_bresp};
endmodule

// File: doc/axis2axi_wr_responder.md
Name: axis2axi_wr_responder

Overview:
- Target-side write endpoint of the XY mesh.
- Consumes write-request packets from a router's HOME_REQ output port: routing header flit, then AW subheader flit, then W data flits.
- Replays each packet as one AXI4 write burst on an AXI master port, waits for B, then returns a B response packet (routing header + B subheader) on the HOME_RESP input of the same router.
- It is the responder counterpart of the initiator-side write packetizer in the AXI-to-AXIS bridge.

Parameters:
- ADDR_WIDTH, 16, AXI address width.
- DATA_WIDTH, 8, AXI data width; must be ≤ AXIS_CHANNEL_WIDTH.
- ID_W_WIDTH, 5, AXI write ID width.
- AXIS_CHANNEL_WIDTH, 40, flit width; ≥ every header/subheader width.
- ROUTER_X, 0, own X coordinate.
- ROUTER_Y, 0, own Y coordinate.
- MAX_ROUTERS_X, 4, mesh width; X_W = $clog2(MAX_ROUTERS_X).
- MAX_ROUTERS_Y, 4, mesh height; Y_W = $clog2(MAX_ROUTERS_Y).

Ports:
- ACLK  in  1  clock.
- ARESETn  in  1  asynchronous active-low reset.
- s_axis_tvalid / s_axis_tready  in / out  1 / 1  request flit handshake.
- s_axis_tdata  in  AXIS_CHANNEL_WIDTH  request flit.
- s_axis_tlast  in  1  last flit of packet.
- m_axis_tvalid / m_axis_tready  out / in  1 / 1  response flit handshake.
- m_axis_tdata  out  AXIS_CHANNEL_WIDTH  response flit.
- m_axis_tlast  out  1  last response flit.
- m_axi_awid / awaddr / awlen / awsize / awburst  out  ID_W_WIDTH / ADDR_WIDTH / 8 / 3 / 2  AW fields.
- m_axi_awvalid / m_axi_awready  out / in  1 / 1  AW handshake.
- m_axi_wdata / m_axi_wlast / m_axi_wvalid  out  DATA_WIDTH / 1 / 1  W fields.
- m_axi_wready  in  1  W handshake.
- m_axi_bid / m_axi_bresp / m_axi_bvalid  in  ID_W_WIDTH / 2 / 1  B fields.
- m_axi_bready  out  1  B handshake.
- proto_err_o  out  1  sticky packet-format error flag.

Behaviour:
- Routing header layout, LSB first: [7:0] type, dst_x (X_W), dst_y (Y_W), src_x (X_W), src_y (Y_W); upper bits zero. Type codes: AW = 8'h01, B = 8'h02.
- AW subheader layout, LSB first: burst[1:0], size[4:2], len[12:5], addr, id.
- B subheader layout: id in the LSBs, rest zero.
- Reset: state IDLE. All valid/ready outputs 0; m_axis_tdata, m_axis_tlast and all AXI payload outputs 0; proto_err_o 0; beat counter 0.
- FSM states:
  - IDLE: s_axis_tready=1. On handshake, latch src_x/src_y. If type==AW and tlast==0, go to SUB. Otherwise set proto_err_o and go to DROP; if tlast==1 on a bad header, return to IDLE directly.
  - SUB: s_axis_tready=1. On handshake, latch the AW fields and load cnt=len. If tlast==1, set err and go to IDLE (no AXI traffic). Else go to AW.
  - AW: awvalid=1, held with stable fields until awready; then go to W. AW is issued before any W beat.
  - W: wvalid=s_axis_tvalid, s_axis_tready=m_axi_wready (combinational pass-through, zero added latency). wdata = tdata[DATA_WIDTH-1:0]; wlast = (cnt==0). Each beat decrements cnt.
    - Beat with cnt==0: go to B. If that beat has tlast==0, set err and go to DRAIN.
    - Beat with tlast==1 while cnt!=0: set err, pad the remaining beats with wdata=0 and s_axis_tready=0 until the wlast beat, then go to B.
  - DRAIN: s_axis_tready=1, discard flits until tlast, then go to B.
  - B: bready=1; on bvalid, latch bid, go to RH.
  - RH: m_axis_tvalid=1, tdata = {src_y,src_x (now destination), ROUTER_Y, ROUTER_X (now source), type 8'h02} in header layout, tlast=0. On tready go to RB.
  - RB: tdata=bid, tlast=1. On tready go to IDLE.
  - DROP: s_axis_tready=1 until the tlast handshake, then go to IDLE.
- m_axis_tvalid, once asserted, holds with stable tdata until tready.
- bresp is ignored unless the optional feature below is enabled.
- One transaction outstanding at a time; a back-to-back packet is accepted in the cycle after leaving RB.
- proto_err_o clears only on reset.

Optional Feature:
- Macro: WR_B_TIMEOUT_EN.
- Enabled:
  - Adds parameter TIMEOUT_CYCLES (default 1024).
  - A counter runs while in state B.
  - If TIMEOUT_CYCLES cycles elapse with no bvalid, go to RH with B id = latched awid, and set proto_err_o.
  - A late bvalid arriving afterwards in IDLE is accepted (bready=1) and discarded.
- Disabled: B waits indefinitely; no counter is present.

Test Plan:
- Packet {hdr type 01 src(2,1) dst(0,0), AW id=5 addr=16'h0040 len=3 size=0 burst=1, 4 data flits AA,BB,CC,DD (tlast on DD)}, awready/wready always 1, bvalid 2 cycles after wlast with bid=5 -> expected:
  - one AW: addr 0040, len 3;
  - 4 W beats, wlast on DD;
  - response flits: header with type 02, dst(2,1), src(0,0), then tdata=5 with tlast=1.
- Same packet with random awready/wready/m_axis_tready back-pressure -> identical AXI and response contents; no beat lost or duplicated.
- Header with type 8'h03, 3 flits -> all 3 flits consumed; no AXI activity; proto_err_o=1; no response.
- len=3 but tlast on the 2nd data flit -> 4 W beats, last two with wdata=0 and wlast on the 4th; proto_err_o=1; B response still sent.
- ARESETn asserted during W state after 2 beats -> all outputs 0 immediately; after release, a fresh len=0 packet completes normally.
- WR_B_TIMEOUT_EN with TIMEOUT_CYCLES=16, bvalid held low -> response packet sent 16 cycles after entering B, carrying the latched awid; proto_err_o=1.
